// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the cache address, captures hit data into a
// small {pc,instr} buffer toward decode, and flushes on execute redirects.
module instr_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] i_addr_pre,
   output logic [15:0] i_addr,
   input  logic [15:0] instr,
   input  logic        i_hit,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_instr,
   output logic [15:0] out_pc
);

   localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

   state_t         state_reg, state_next;
   logic [15:0]    pc_reg;
   logic [PW-1:0]  head_reg, tail_reg;
   logic [CW-1:0]  count_reg;
   logic           pop, accept;
   logic [15:0]    ent_pc    [DEPTH];
   logic [15:0]    ent_instr [DEPTH];

   // Circular pointer advance that also works for non-power-of-two depths.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // State register: BOOT lasts exactly one cycle after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= BOOT;
      else     state_reg <= state_next;
   end

   // Next-state logic: BOOT always completes to RUN, redirects cannot cut it short.
   always_comb begin
      state_next = state_reg;
      if (state_reg == BOOT) state_next = RUN;
   end

   // Output logic: handshake decisions and the address presented to the cache.
   always_comb begin
      pop        = 1'b0;
      accept     = 1'b0;
      i_addr_pre = pc_reg;
      case (state_reg)
         BOOT: i_addr_pre = RESET_PC;
         RUN: begin
            pop    = (count_reg != '0) && out_ready && !redirect;
            accept = i_hit && !redirect && ((count_reg < DEPTH_C) || pop);
            if (redirect)    i_addr_pre = redirect_pc;
            else if (accept) i_addr_pre = pc_reg + 16'd1;
         end
         default: i_addr_pre = pc_reg;
      endcase
   end

   // PC and buffer bookkeeping; pc always follows the address just presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_reg    <= RESET_PC;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else if (state_reg == RUN) begin
         pc_reg <= i_addr_pre;
         if (redirect) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
         end else begin
            if (accept) tail_reg <= ptr_inc(tail_reg);
            if (pop)    head_reg <= ptr_inc(head_reg);
            case ({accept, pop})
               2'b10:   count_reg <= count_reg + CW'(1);
               2'b01:   count_reg <= count_reg - CW'(1);
               default: count_reg <= count_reg;
            endcase
         end
      end
   end

   // Buffer entries: one register pair per slot, written when the tail points at it.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [15:0] pc_reg_e;
      logic [15:0] instr_reg_e;

      // Capture {pc,instr} on an accepted hit into this slot.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            pc_reg_e    <= '0;
            instr_reg_e <= '0;
         end else if (accept && (tail_reg == PW'(gi))) begin
            pc_reg_e    <= pc_reg;
            instr_reg_e <= instr;
         end
      end

      assign ent_pc[gi]    = pc_reg_e;
      assign ent_instr[gi] = instr_reg_e;
   end

   assign i_addr    = pc_reg;
   assign out_valid = (count_reg != '0);
   assign out_pc    = ent_pc[head_reg];
   assign out_instr = ent_instr[head_reg];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a behavioural cache (instr = addr ^ A000) plus a
// queue-based model of the fetch buffer, driven by directed and random stimulus.
module tb_instr_fetch;

   localparam logic [15:0] RESET_PC = 16'h0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] i_addr_pre, i_addr, instr, redirect_pc, out_instr, out_pc;
   logic        i_hit, redirect, out_valid, out_ready;

   logic [15:0] cache_addr;

   int checks = 0;
   int errors = 0;

   // Model state: boot flag, fetch pc, and the pcs waiting in the buffer.
   bit          m_boot;
   logic [15:0] m_pc;
   logic [15:0] m_q[$];

   instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_addr_pre  (i_addr_pre),
      .i_addr      (i_addr),
      .instr       (instr),
      .i_hit       (i_hit),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc)
   );

   always #5 clk = ~clk;

   // Single-cycle cache: latches the address at the edge, returns data next cycle.
   always @(posedge clk) cache_addr <= i_addr_pre;
   assign instr = cache_addr ^ 16'hA000;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_boot = 1'b1;
      m_pc   = RESET_PC;
      m_q.delete();
   endtask

   // One clock cycle: entered and left at posedge+1.
   task automatic cycle(input logic r, input logic [15:0] rpc, input logic hit, input logic rdy);
      bit          m_pop, m_acc;
      logic [15:0] exp_pre;
      redirect    = r;
      redirect_pc = rpc;
      i_hit       = hit;
      out_ready   = rdy;
      @(negedge clk);
      m_pop   = !m_boot && (m_q.size() != 0) && rdy && !r;
      m_acc   = !m_boot && hit && !r && ((m_q.size() < DEPTH) || m_pop);
      exp_pre = m_boot ? RESET_PC : (r ? rpc : (m_acc ? m_pc + 16'd1 : m_pc));
      check("i_addr_pre", i_addr_pre, exp_pre);
      check("i_addr", i_addr, m_pc);
      check("out_valid", {15'd0, out_valid}, {15'd0, (m_q.size() != 0)});
      if (m_q.size() != 0) begin
         check("out_pc", out_pc, m_q[0]);
         check("out_instr", out_instr, m_q[0] ^ 16'hA000);
      end
      if (m_pop) $display("pop pc=%h instr=%h", out_pc, out_instr);
      if (m_boot) m_boot = 1'b0;
      else if (r) begin
         m_q.delete();
         m_pc = rpc;
      end else begin
         if (m_pop) void'(m_q.pop_front());
         if (m_acc) begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 16'd1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Hold reset across edges, check reset outputs, release at posedge+1 (cycle 0).
   task automatic apply_reset();
      rst = 1'b1;
      redirect = 1'b0; redirect_pc = '0; i_hit = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {15'd0, out_valid}, 16'd0);
      check("rst_out_pc", out_pc, 16'h0000);
      check("rst_out_instr", out_instr, 16'h0000);
      check("rst_i_addr", i_addr, RESET_PC);
      check("rst_i_addr_pre", i_addr_pre, RESET_PC);
      rst = 1'b0;
      model_reset();
   endtask

   // Streaming from reset: first word at cycle 2, consecutive pcs thereafter.
   task automatic boot_stream();
      logic [15:0] e;
      for (int c = 0; c < 6; c++) begin
         if (c < 2) check("boot_valid_low", {15'd0, out_valid}, 16'd0);
         else begin
            e = 16'(c - 2);
            check("boot_valid", {15'd0, out_valid}, 16'd1);
            check("boot_pc", out_pc, RESET_PC + e);
            check("boot_instr", out_instr, (RESET_PC + e) ^ 16'hA000);
         end
         cycle(1'b0, 16'h0, 1'b1, 1'b1);
      end
   endtask

   initial begin
      logic [15:0] e;
      logic [15:0] rpc;
      int          n;

      // Scenario 1: basic streaming after reset.
      apply_reset();
      boot_stream();

      // Scenario 2/3: backpressure saturates the buffer, release, refill, redirect.
      apply_reset();
      repeat (2) cycle(1'b0, 16'h0, 1'b1, 1'b1);
      repeat (6) cycle(1'b0, 16'h0, 1'b1, 1'b0);
      check("bp_i_addr_held", i_addr, 16'h0002);
      check("bp_head_pc", out_pc, 16'h0000);
      repeat (6) cycle(1'b0, 16'h0, 1'b1, 1'b1);
      repeat (4) cycle(1'b0, 16'h0, 1'b1, 1'b0);
      cycle(1'b1, 16'h1000, 1'b1, 1'b1);
      check("flush_valid_low", {15'd0, out_valid}, 16'd0);
      cycle(1'b0, 16'h0, 1'b1, 1'b1);
      check("flush_target_pc", out_pc, 16'h1000);
      repeat (3) cycle(1'b0, 16'h0, 1'b1, 1'b1);

      // Scenario 4: miss bubble at pc=5.
      apply_reset();
      n = 0;
      while (m_pc != 16'h0005 && n < 20) begin
         cycle(1'b0, 16'h0, 1'b1, 1'b1);
         n++;
      end
      check("reach_pc5", m_pc, 16'h0005);
      repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b1);
      check("miss_hold_pc", i_addr, 16'h0005);
      repeat (5) cycle(1'b0, 16'h0, 1'b1, 1'b1);

      // Scenario 5: redirect to the top of the address space wraps.
      cycle(1'b1, 16'hFFFF, 1'b1, 1'b1);
      cycle(1'b0, 16'h0, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         e = 16'hFFFF + 16'(k);
         check("wrap_pc", out_pc, e);
         cycle(1'b0, 16'h0, 1'b1, 1'b1);
      end

      // Scenario 6: asynchronous reset mid-cycle while streaming.
      redirect = 1'b0; i_hit = 1'b1; out_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("async_valid", {15'd0, out_valid}, 16'd0);
      check("async_i_addr_pre", i_addr_pre, RESET_PC);
      check("async_i_addr", i_addr, RESET_PC);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      boot_stream();

      // Random phase against the model.
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 3))
            0:       rpc = 16'hFFFF;
            1:       rpc = 16'hFFFE;
            default: rpc = 16'($urandom);
         endcase
         cycle(($urandom_range(0, 15) == 0), rpc,
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-cycle-memory processor. Generates the next fetch address for the unified cache and its registered copy, and captures returned instruction words when the cache reports a hit. Fetched words are queued in a small buffer toward decode with a valid/ready handshake. Applies branch/jump redirects from execute with a full flush.

## Interface
- RESET_PC, 16'h0000, fetch address after reset
- DEPTH, 2, fetch buffer entries (legal: 2..4)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- i_addr_pre  out  16  next fetch address; the cache samples it on posedge clk
- i_addr  out  16  address of the word currently on instr (the registered pc)
- instr  in  16  instruction word for i_addr
- i_hit  in  1  instr valid this cycle
- redirect  in  1  flush-and-jump request from execute
- redirect_pc  in  16  jump target, valid with redirect
- out_valid  out  1  buffer head valid
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  16  head instruction
- out_pc  out  16  address of out_instr

## Operation
- State: BOOT, RUN; pc[15:0]; FIFO of DEPTH {pc,instr} entries with count.
- Reset (async): state=BOOT, pc=RESET_PC, count=0, all entries 0. Outputs: out_valid=0, out_instr=0, out_pc=0, i_addr=RESET_PC, i_addr_pre=RESET_PC.
- BOOT: i_addr_pre=RESET_PC, no push. Next edge: state=RUN, pc unchanged. This primes the cache's address latch independently of reset deassertion timing.
- RUN, pop = out_valid & out_ready & ~redirect.
- RUN, accept = i_hit & ~redirect & (count<DEPTH | pop).
- Priority, highest first:
  1. redirect: i_addr_pre=redirect_pc; next pc=redirect_pc; count<=0; no push; pop ignored.
  2. accept: push {pc,instr}; i_addr_pre=pc+1; next pc=pc+1.
  3. otherwise (miss or buffer full): i_addr_pre=pc; pc holds, and the same address is re-presented.
- pc+1 is 16-bit modulo: 16'hFFFF -> 16'h0000.
- Push and pop in the same cycle: count unchanged, order preserved.
- out_valid = (count!=0). out_instr and out_pc come from the head entry and are stable while out_valid & ~out_ready.
- redirect in BOOT: ignored; BOOT always completes to RESET_PC.
- i_addr = pc (registered). i_addr_pre is combinational from state, pc, redirect, accept. No combinational path from instr to any output; out_ready reaches only i_addr_pre.

## Timing
- Fetch latency: address on i_addr_pre at edge N, then instr valid during cycle N+1, push at edge N+1, out_valid during cycle N+2.
- After reset deassertion: cycle 0 BOOT; cycle 1 instr(RESET_PC) on bus; cycle 2 out_valid=1, out_pc=RESET_PC.
- Steady state with i_hit=1 and out_ready=1: one instruction per cycle, consecutive pcs.
- Redirect asserted in cycle k: out_valid=0 in cycle k+1; target at the head in cycle k+2 (2-cycle bubble).
- i_hit=0 for m cycles: m-cycle bubble; no duplicate or skipped pc.
- Backpressure: at count=DEPTH with no pop, accept=0 and pc holds; the fetch resumes the cycle pop occurs.
- rst asserted mid-cycle: outputs take reset values immediately, without waiting for clk.

## Test plan
- Reset, RESET_PC=0, memory[0..3]=A000..A003, out_ready=1 -> out_valid first in cycle 2; (out_pc,out_instr)=(0,A000),(1,A001),(2,A002),(3,A003) on consecutive cycles.
- out_ready=0 for 6 cycles from cycle 2 -> count saturates at DEPTH=2, i_addr_pre held at 2; release -> pcs 0,1,2,3 in order, none lost or duplicated.
- Buffer full, redirect=1 with redirect_pc=16'h1000 and out_ready=1 -> out_valid=0 next cycle; out_pc=1000 two cycles after redirect; pcs 0/1 never emitted after flush.
- i_hit=0 for 3 cycles while pc=5 -> i_addr_pre=5 held, no push; then pc 5 emitted exactly once, followed by 6.
- redirect_pc=16'hFFFF -> out_pc sequence FFFF, 0000, 0001.
- rst pulsed between clock edges during streaming -> out_valid=0 and i_addr_pre=RESET_PC immediately; restart matches the first scenario's timing.
